// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte/half/word data memory with clear sweep, misalignment errors and pipelined loads
module dmem_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  input  logic                  i_clear,
  output logic                  o_ready,
  output logic                  o_rvalid,
  output logic [31:0]           o_rdata,
  output logic                  o_err
);
  localparam int WW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WW;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                         st;
  logic [WW-1:0]                  cnt;
  logic [31:0]                    mem [DEPTH];
  logic [WW-1:0]                  widx;
  logic [1:0]                     lane;
  logic                           acc, bad, ld, st_ok, serr;
  logic [3:0]                     be;
  logic [31:0]                    wd, word, ext;
  logic [15:0]                    sh;
  logic [READ_LATENCY-1:0]        vld, perr;
  logic [READ_LATENCY-1:0][31:0]  dat;
  always_comb begin
    widx  = i_addr[ADDR_WIDTH-1:2];
    lane  = i_addr[1:0];
    acc   = i_req & o_ready;
    bad   = (i_size == 2'b11) | (i_size == 2'b01 & lane[0]) | (i_size == 2'b10 & |lane);
    ld    = acc & ~i_we;
    st_ok = acc & i_we & ~bad;
    be    = i_size == 2'b00 ? 4'b0001 << lane : i_size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd    = i_size == 2'b00 ? {4{i_wdata[7:0]}} : i_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
    word  = mem[widx];
    sh    = 16'(word >> {lane, 3'b000});
    ext   = bad ? '0 :
            i_size == 2'b00 ? {{24{~i_unsigned & sh[7]}}, sh[7:0]} :
            i_size == 2'b01 ? {{16{~i_unsigned & sh[15]}}, sh[15:0]} : word;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      st      <= CLEAR;
      cnt     <= '0;
      o_ready <= 1'b0;
    end else if (st == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        st      <= RUN;
        o_ready <= 1'b1;
      end
    end else if (i_clear) begin
      st      <= CLEAR;
      cnt     <= '0;
      o_ready <= 1'b0;
    end
  always_ff @(posedge i_clk)
    if (st == CLEAR) mem[cnt] <= '0;
    else if (st_ok)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
  // Load results are extracted at acceptance and then only shifted, so a clear cannot disturb them
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      vld  <= '0;
      perr <= '0;
      dat  <= '0;
      serr <= 1'b0;
    end else begin
      vld[0]  <= ld;
      perr[0] <= ld & bad;
      dat[0]  <= ld ? ext : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i]  <= vld[i-1];
        perr[i] <= perr[i-1];
        dat[i]  <= dat[i-1];
      end
      serr <= acc & i_we & bad;
    end
  assign o_rvalid = vld[READ_LATENCY-1];
  assign o_rdata  = dat[READ_LATENCY-1];
  assign o_err    = serr | perr[READ_LATENCY-1];
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized check of dmem_ctrl at latencies 1, 2 and 4 against a byte-array model
module tb_dmem_ctrl;
  localparam int DEPTH = 256;
  localparam int MAXE  = 16384;
  logic        clk = 0, rst_n = 1, req = 0, we = 0, uns = 0, clear = 0;
  logic [1:0]  size = 0;
  logic [9:0]  addr = 0;
  logic [31:0] wdata = 0;
  logic        rdy [3], rv [3], er [3];
  logic [31:0] rd [3];
  bit          ex_v [3][MAXE];
  bit          ex_e [3][MAXE];
  logic [31:0] ex_d [3][MAXE];
  logic [7:0]  mb [1024];
  int          e = 0, left = DEPTH, errors = 0, checks = 0;
  bit          rdy_m = 0, go = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : dut
    dmem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(g == 0 ? 1 : g == 1 ? 2 : 4)) u (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
      .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata), .i_clear(clear),
      .o_ready(rdy[g]), .o_rvalid(rv[g]), .o_rdata(rd[g]), .o_err(er[g]));
  end
  function automatic int lat(int j);
    return j == 0 ? 1 : j == 1 ? 2 : 4;
  endfunction
  function automatic bit mis(logic [1:0] s, int a);
    return s == 3 || (s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0);
  endfunction
  function automatic logic [31:0] mload(logic [1:0] s, bit u, int a);
    int b, v;
    if (mis(s, a)) return 0;
    b = a - a % 4;
    if (s == 2) return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    if (s == 1) begin
      v = int'(mb[a]) + 256 * int'(mb[a+1]);
      return (u || v < 32768) ? v : v - 65536;
    end
    v = int'(mb[a]);
    return (u || v < 128) ? v : v - 256;
  endfunction
  task automatic chk(string nm, int j, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat=%0d edge=%0d: got %h expected %h", nm, lat(j), e, act, exp);
    end
  endtask
  task automatic pin(string nm, logic [31:0] m, logic [31:0] lit);
    checks++;
    if (m !== lit) begin
      errors++;
      $display("FAIL model_%s: got %h expected %h", nm, m, lit);
    end
  endtask
  task automatic zero_mem();
    for (int i = 0; i < 1024; i++) mb[i] = 0;
  endtask
  task automatic step(bit r, bit w, logic [1:0] s, bit u, int a, logic [31:0] d, bit c);
    if (e + 8 >= MAXE) begin
      $display("FAIL edge_budget: got %0d expected below %0d", e, MAXE);
      $fatal(1);
    end
    req = r; we = w; size = s; uns = u; addr = a[9:0]; wdata = d; clear = c;
    if (rst_n && rdy_m && r) begin
      if (!w)
        for (int j = 0; j < 3; j++) begin
          ex_v[j][e+lat(j)] = 1;
          ex_e[j][e+lat(j)] = ex_e[j][e+lat(j)] | mis(s, a);
          ex_d[j][e+lat(j)] = mload(s, u, a);
        end
      else if (mis(s, a))
        for (int j = 0; j < 3; j++) ex_e[j][e+1] = 1;
      else begin
        mb[a] = d[7:0];
        if (s >= 1) mb[a+1] = d[15:8];
        if (s == 2) begin
          mb[a+2] = d[23:16];
          mb[a+3] = d[31:24];
        end
      end
    end
    @(posedge clk);
    e++;
    if (rst_n) begin
      if (left > 0) left--;
      else if (c) begin
        left = DEPTH;
        zero_mem();
      end
    end
    rdy_m = rst_n && left == 0;
    @(negedge clk);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic sw(int a, logic [31:0] d, logic [1:0] s = 2);
    step(1, 1, s, 0, a, d, 0);
  endtask
  task automatic lw(int a, logic [1:0] s = 2, bit u = 0);
    step(1, 0, s, u, a, 0, 0);
  endtask
  task automatic wait_ready(string nm);
    int n = 0;
    do begin
      idle();
      n++;
    end while (!rdy[1] && n < 1000);
    chk(nm, 1, n, DEPTH);
  endtask
  task automatic areset();
    #2 rst_n = 0;
    req = 0;
    clear = 0;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("rst_ready", j, rdy[j], 0);
      chk("rst_rvalid", j, rv[j], 0);
      chk("rst_err", j, er[j], 0);
      chk("rst_rdata", j, rd[j], 0);
    end
    for (int j = 0; j < 3; j++)
      for (int i = e + 1; i < MAXE; i++) begin
        ex_v[j][i] = 0;
        ex_e[j][i] = 0;
      end
    left = DEPTH;
    rdy_m = 0;
    zero_mem();
    @(posedge clk);
    e++;
    @(negedge clk);
    repeat (2) idle();
    rst_n = 1;
    wait_ready("ready_after_reset");
  endtask
  always @(negedge clk) begin
    #1;
    if (go)
      for (int j = 0; j < 3; j++) begin
        chk("ready", j, rdy[j], rdy_m);
        chk("rvalid", j, rv[j], ex_v[j][e]);
        chk("err", j, er[j], ex_e[j][e]);
        if (ex_v[j][e]) chk("rdata", j, rd[j], ex_d[j][e]);
      end
  end
  initial begin
    zero_mem();
    #1 rst_n = 0;
    @(negedge clk);
    idle();
    go = 1;
    repeat (2) idle();
    rst_n = 1;
    wait_ready("ready_after_reset");
    pin("lw10", mload(2, 0, 'h10), 32'h0);
    lw('h10);
    sw('h0, 32'h800000F1);
    pin("lb0", mload(0, 0, 0), 32'hFFFFFFF1);
    pin("lbu0", mload(0, 1, 0), 32'h000000F1);
    pin("lh2", mload(1, 0, 2), 32'hFFFF8000);
    pin("lhu2", mload(1, 1, 2), 32'h00008000);
    lw('h0, 0, 0);
    lw('h0, 0, 1);
    lw('h2, 1, 0);
    lw('h2, 1, 1);
    sw('h4, 32'h11223344);
    sw('h5, 32'h123456AA, 0);
    sw('h6, 32'h9876BEEF, 1);
    pin("lw4", mload(2, 0, 4), 32'hBEEFAA44);
    lw('h4);
    sw('h0, 32'd1111);
    sw('h4, 32'd2222);
    sw('h8, 32'd3333);
    pin("lw8", mload(2, 0, 8), 32'd3333);
    lw('h0);
    lw('h4);
    lw('h8);
    repeat (5) idle();
    pin("mis_lw2", mis(2, 2), 1);
    lw('h2);
    sw('h3, 32'hDEAD, 1);
    lw('h0);
    lw('h8, 3);
    sw('h8, 32'h0, 3);
    lw('h8);
    repeat (5) idle();
    for (int i = 0; i < 16; i++) sw(4 * i, $urandom);
    lw('hC);
    step(0, 0, 0, 0, 0, 0, 1);
    wait_ready("ready_after_clear");
    for (int i = 0; i < DEPTH; i++) lw(4 * i);
    repeat (5) idle();
    sw('h20, 32'hCAFEF00D);
    step(1, 0, 2, 0, 'h20, 0, 1);
    wait_ready("ready_after_clear_ld");
    lw('h20);
    sw('h24, 32'h5A5A1234);
    lw('h24);
    areset();
    lw('h24);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (100) idle();
    areset();
    for (int k = 0; k < 600; k++) begin
      logic [1:0] s;
      s = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      if (!rdy_m) idle();
      else step($urandom % 4 != 0, $urandom % 2, s, $urandom % 2, $urandom % 32, $urandom, $urandom % 250 == 0);
    end
    repeat (6) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
